// File: rtl/bcd_seg_display_seq.sv
// Sequential binary-to-decimal 7-segment driver.
// An IN_W-bit unsigned value is converted with double-dabble, one shift per
// clock, then latched onto NDIG active-low digits (gfedcba, digit 0 = ones).
// Leading-zero blanking is optional. Values above 10^NDIG-1 show dashes and
// raise overflow.
// Handshake: load is sampled only while idle (busy=0). A load seen while busy
// is dropped, not queued. Each accepted load produces exactly one done pulse,
// and hex_out/overflow become valid in that same cycle. The FSM state is kept
// in the named register 'state'.
module bcd_seg_display_seq #(
  parameter int IN_W     = 8,
  parameter int NDIG     = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [IN_W-1:0]      value,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [7*NDIG-1:0]    hex_out
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int BCD_W = 4 * NDIG;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Largest value that fits in NDIG decimal digits.
  localparam int MAX_VAL = pow10(NDIG) - 1;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0011000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Display of zero: ones digit shows 0, the rest blank or 0 by BLANK_LZ.
  function automatic logic [7*NDIG-1:0] reset_hex();
    logic [7*NDIG-1:0] h;
    for (int i = 0; i < NDIG; i++)
      h[7*i +: 7] = (i == 0 || BLANK_LZ == 0) ? SEG_ZERO : SEG_BLANK;
    return h;
  endfunction

  localparam logic [7*NDIG-1:0] RESET_HEX = reset_hex();

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t             state;
  logic [IN_W-1:0]    bin;
  logic [BCD_W-1:0]   bcd;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_pend;
  logic [BCD_W-1:0]   bcd_adj;
  logic [7*NDIG-1:0]  hex_next;
  logic               lead;
  logic [3:0]         nib;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NDIG; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  // Segment image of the finished BCD, walking from the top digit down so
  // blanking stops at the first non-zero digit.
  always_comb begin
    hex_next = '0;
    lead     = 1'b1;
    nib      = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      nib = bcd[4*i +: 4];
      if (ovf_pend) begin
        hex_next[7*i +: 7] = SEG_DASH;
      end else if (BLANK_LZ != 0 && lead && nib == 4'd0 && i != 0) begin
        hex_next[7*i +: 7] = SEG_BLANK;
      end else begin
        hex_next[7*i +: 7] = seg7(nib);
        lead = 1'b0;
      end
    end
  end

  // Conversion FSM. Outputs are registered, and only LATCH writes the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      hex_out  <= RESET_HEX;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            bin      <= value;
            bcd      <= '0;
            cnt      <= CNT_W'(IN_W);
            ovf_pend <= (32'(value) > 32'(MAX_VAL));
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // Carries out of the top nibble are dropped; ovf_pend covers them.
          {bcd, bin} <= {bcd_adj[BCD_W-2:0], bin, 1'b0};
          cnt        <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= LATCH;
        end
        LATCH: begin
          hex_out  <= hex_next;
          overflow <= ovf_pend;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seg_display_seq.sv
// Bench for bcd_seg_display_seq. Five instances cover the configurations of
// interest:
//   0: (8,3,blank)   1: (8,3,no blank)   2: (8,2,blank)
//   3: (16,5,blank)  4: (16,4,blank)
// Each expected result is pushed as {id, overflow, hex} when its load is
// issued. A monitor pops one entry on every done pulse of any instance.
module tb_bcd_seg_display_seq;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S9 = 7'b0011000;
  localparam logic [6:0] BLK = 7'b1111111, DSH = 7'b0111111;

  localparam int W = 39;

  logic        clk;
  logic        rst;
  logic [4:0]  load_v;
  logic [7:0]  value8;
  logic [15:0] value16;
  logic [4:0]  busy_v, done_v, ovf_v;
  logic [20:0] hex0, hex1;
  logic [13:0] hex2;
  logic [34:0] hex3;
  logic [27:0] hex4;
  logic [34:0] hex_v [5];

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  assign hex_v[0] = 35'(hex0);
  assign hex_v[1] = 35'(hex1);
  assign hex_v[2] = 35'(hex2);
  assign hex_v[3] = hex3;
  assign hex_v[4] = 35'(hex4);

  bcd_seg_display_seq #(.IN_W(8), .NDIG(3), .BLANK_LZ(1)) u0 (
    .clk(clk), .rst(rst), .load(load_v[0]), .value(value8), .busy(busy_v[0]),
    .done(done_v[0]), .overflow(ovf_v[0]), .hex_out(hex0));
  bcd_seg_display_seq #(.IN_W(8), .NDIG(3), .BLANK_LZ(0)) u1 (
    .clk(clk), .rst(rst), .load(load_v[1]), .value(value8), .busy(busy_v[1]),
    .done(done_v[1]), .overflow(ovf_v[1]), .hex_out(hex1));
  bcd_seg_display_seq #(.IN_W(8), .NDIG(2), .BLANK_LZ(1)) u2 (
    .clk(clk), .rst(rst), .load(load_v[2]), .value(value8), .busy(busy_v[2]),
    .done(done_v[2]), .overflow(ovf_v[2]), .hex_out(hex2));
  bcd_seg_display_seq #(.IN_W(16), .NDIG(5), .BLANK_LZ(1)) u3 (
    .clk(clk), .rst(rst), .load(load_v[3]), .value(value16), .busy(busy_v[3]),
    .done(done_v[3]), .overflow(ovf_v[3]), .hex_out(hex3));
  bcd_seg_display_seq #(.IN_W(16), .NDIG(4), .BLANK_LZ(1)) u4 (
    .clk(clk), .rst(rst), .load(load_v[4]), .value(value16), .busy(busy_v[4]),
    .done(done_v[4]), .overflow(ovf_v[4]), .hex_out(hex4));

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk(input int id, input logic ovf, input logic [34:0] hex);
    return {3'(id), ovf, hex};
  endfunction

  task automatic check(input string name, input logic [34:0] got, input logic [34:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Called on a negedge; holds load for exactly one rising edge.
  task automatic issue(input int id, input logic [15:0] val, input bit push,
                       input logic [W-1:0] exp);
    value8      = val[7:0];
    value16     = val;
    load_v[id]  = 1'b1;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    load_v[id]  = 1'b0;
  endtask

  task automatic wait_done(input int id, input int budget, output int n);
    n = 0;
    while (!done_v[id] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done_v[id]) begin
      checks++;
      errors++;
      $display("FAIL done_timeout dut%0d got no done want done within %0d", id, budget);
    end
  endtask

  // Scoreboard monitor
  logic [W-1:0] got_r, want_r;
  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (done_v[k]) begin
        checks++;
        got_r = {3'(k), ovf_v[k], hex_v[k]};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done dut%0d got %h want no result", k, got_r);
        end else begin
          want_r = exp_q.pop_front();
          if (got_r !== want_r) begin
            errors++;
            $display("FAIL result dut%0d got %h want %h", k, got_r, want_r);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int n;
    rst = 1'b1; load_v = '0; value8 = '0; value16 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_busy",     35'(busy_v[0]), 35'd0);
    check("reset_done",     35'(done_v[0]), 35'd0);
    check("reset_overflow", 35'(ovf_v[0]),  35'd0);
    check("reset_hex",      hex_v[0],       35'({BLK, BLK, S0}));
    check("reset_hex_noblank", hex_v[1],    35'({S0, S0, S0}));

    // 255: busy for 9 cycles, then a single done pulse
    issue(0, 16'd255, 1'b1, mk(0, 1'b0, 35'({S2, S5, S5})));
    n = 0;
    while (busy_v[0] && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 35'(n), 35'd9);
    check("done_pulse", 35'(done_v[0]), 35'd1);
    @(negedge clk);
    check("done_clear", 35'(done_v[0]), 35'd0);

    // Blanking on/off, and zero
    issue(0, 16'd7, 1'b1, mk(0, 1'b0, 35'({BLK, BLK, S7})));
    wait_done(0, 40, n);
    issue(1, 16'd7, 1'b1, mk(1, 1'b0, 35'({S0, S0, S7})));
    wait_done(1, 40, n);
    issue(0, 16'd0, 1'b1, mk(0, 1'b0, 35'({BLK, BLK, S0})));
    wait_done(0, 40, n);

    // Two-digit overflow boundary
    issue(2, 16'd99, 1'b1, mk(2, 1'b0, 35'({S9, S9})));
    wait_done(2, 40, n);
    issue(2, 16'd100, 1'b1, mk(2, 1'b1, 35'({DSH, DSH})));
    wait_done(2, 40, n);
    issue(2, 16'd5, 1'b1, mk(2, 1'b0, 35'({BLK, S5})));
    wait_done(2, 40, n);

    // A load while busy is ignored; a load in the done cycle is accepted
    issue(0, 16'd200, 1'b1, mk(0, 1'b0, 35'({S2, S0, S0})));
    repeat (3) @(negedge clk);
    issue(0, 16'd13, 1'b0, '0);
    wait_done(0, 40, n);
    issue(0, 16'd13, 1'b1, mk(0, 1'b0, 35'({BLK, S1, S3})));
    wait_done(0, 40, n);
    check("latency_done_cycle_load", 35'(n), 35'd9);

    // Reset in the middle of a conversion
    @(negedge clk);
    issue(0, 16'd255, 1'b0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy",     35'(busy_v[0]), 35'd0);
    check("midrst_done",     35'(done_v[0]), 35'd0);
    check("midrst_overflow", 35'(ovf_v[0]),  35'd0);
    check("midrst_hex",      hex_v[0],       35'({BLK, BLK, S0}));
    repeat (25) @(negedge clk);

    // Wide configurations
    issue(3, 16'd65535, 1'b1, mk(3, 1'b0, 35'({S6, S5, S5, S3, S5})));
    wait_done(3, 60, n);
    check("latency_w16", 35'(n), 35'd17);
    issue(4, 16'd10000, 1'b1, mk(4, 1'b1, 35'({DSH, DSH, DSH, DSH})));
    wait_done(4, 60, n);
    issue(4, 16'd9999, 1'b1, mk(4, 1'b0, 35'({S9, S9, S9, S9})));
    wait_done(4, 60, n);

    repeat (5) @(negedge clk);
    check("queue_drained", 35'(exp_q.size()), 35'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
